// File: rtl/cal_serie.sv
// cal_serie: bit-serial / slice-serial ALU. Operands are latched on an
// accepted start, then consumed SLICE bits per cycle (LSB slice first)
// through a small ripple fed by a registered carry. The result is built
// in a shift register and published to the output registers on the cycle
// the last slice completes, so outputs only ever change on entry to DONE.
module cal_serie #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             l,
    input  logic [1:0]       s,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic             zero,
    output logic             ovf
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;

    // latched operation; a_q/b_q shift right so the active slice is always at bit 0
    logic [WIDTH-1:0] a_q, b_q, sr_q;
    logic             l_q, cy_q;
    logic [1:0]       s_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] out_q;
    logic             busy_q, done_q, c_out_q, zero_q, ovf_q;
    logic             busy_d, done_d;

    logic             load, step, last;
    logic             init_cy;
    logic [SLICE-1:0] as, bs, bb, rs;
    logic [SLICE:0]   rc;
    logic [WIDTH-1:0] sr_nx;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state: start is only looked at outside RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == CW'(N - 1)) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // control strobes and the next values of the registered busy/done flags
    always_comb begin
        load   = (state_q != RUN) && start;
        step   = (state_q == RUN);
        last   = step && (cnt_q == CW'(N - 1));
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // one slice of the ALU; SUB/INC/DEC are folded into ADD by choosing the
    // second operand (~b, 0, all-ones) and the initial carry
    always_comb begin
        as    = a_q[SLICE-1:0];
        bs    = b_q[SLICE-1:0];
        case (s_q)
            2'b00: bb = bs;
            2'b01: bb = ~bs;
            2'b10: bb = '0;
            2'b11: bb = '1;
        endcase
        rc    = '0;
        rs    = '0;
        rc[0] = cy_q;
        for (int i = 0; i < SLICE; i++) begin
            rc[i+1] = (as[i] & bb[i]) | (rc[i] & (as[i] ^ bb[i]));
            if (l_q) begin
                case (s_q)
                    2'b00: rs[i] = as[i] & bs[i];
                    2'b01: rs[i] = as[i] | bs[i];
                    2'b10: rs[i] = as[i] ^ bs[i];
                    2'b11: rs[i] = ~as[i];
                endcase
            end else begin
                rs[i] = as[i] ^ bb[i] ^ rc[i];
            end
        end
        // new slice enters at the top; after N steps the LSB slice is at bit 0
        sr_nx   = (sr_q >> SLICE) | (WIDTH'(rs) << (WIDTH - SLICE));
        init_cy = (s == 2'b00) ? c_in : (s != 2'b11);
    end

    // operand latch, slice stepping and result publication
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            l_q     <= 1'b0;
            s_q     <= 2'b00;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            sr_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            c_out_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (load) begin
                a_q   <= a;
                b_q   <= b;
                l_q   <= l;
                s_q   <= s;
                cy_q  <= init_cy;
                cnt_q <= '0;
            end else if (step) begin
                a_q   <= a_q >> SLICE;
                b_q   <= b_q >> SLICE;
                cy_q  <= rc[SLICE];
                sr_q  <= sr_nx;
                cnt_q <= cnt_q + CW'(1);
            end
            if (last) begin
                out_q   <= sr_nx;
                zero_q  <= (sr_nx == '0);
                c_out_q <= ~l_q & rc[SLICE];
                ovf_q   <= ~l_q & (rc[SLICE] ^ rc[SLICE-1]);
            end
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign out   = out_q;
    assign c_out = c_out_q;
    assign zero  = zero_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_cal_serie.sv
// Bench for cal_serie: an 8-bit/1-bit-slice instance and an 8-bit/4-bit-slice
// instance share the stimulus. A per-instance model (plain 9-bit arithmetic
// plus a busy countdown) is compared every cycle; directed ops also check
// hand-computed literal results and latencies.
module tb_cal_serie;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, l = 1'b0, c_in = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic [1:0] s = '0;

    logic       busy1, done1, c1, z1, v1;
    logic [7:0] o1;
    logic       busy4, done4, c4, z4, v4;
    logic [7:0] o4;

    cal_serie #(.WIDTH(8), .SLICE(1)) u_s1 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .l(l), .s(s), .c_in(c_in),
        .busy(busy1), .done(done1), .out(o1), .c_out(c1), .zero(z1), .ovf(v1));

    cal_serie #(.WIDTH(8), .SLICE(4)) u_s4 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .l(l), .s(s), .c_in(c_in),
        .busy(busy4), .done(done4), .out(o4), .c_out(c4), .zero(z4), .ovf(v4));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // result = {c_out, ovf, out} from plain arithmetic
    function automatic logic [9:0] model_op(input logic [7:0] aa, input logic [7:0] bv,
                                            input logic ll, input logic [1:0] ss, input logic ci);
        logic [7:0] op2;
        logic       cin;
        logic [8:0] sum;
        logic       v;
        if (ll) begin
            case (ss)
                2'b00:   return {2'b00, aa & bv};
                2'b01:   return {2'b00, aa | bv};
                2'b10:   return {2'b00, aa ^ bv};
                default: return {2'b00, ~aa};
            endcase
        end
        case (ss)
            2'b00:   begin op2 = bv;    cin = ci;   end
            2'b01:   begin op2 = ~bv;   cin = 1'b1; end
            2'b10:   begin op2 = 8'h00; cin = 1'b1; end
            default: begin op2 = 8'hFF; cin = 1'b0; end
        endcase
        sum = {1'b0, aa} + {1'b0, op2} + 9'(cin);
        v   = (aa[7] == op2[7]) && (sum[7] != aa[7]);
        return {sum[8], v, sum[7:0]};
    endfunction

    // model: busy for N cycles after an accepted start, then one done cycle
    int         m_left[2];
    bit         m_done[2];
    bit         m_z[2];
    logic [9:0] m_res[2];
    logic [9:0] m_pend[2];
    int         nn;

    initial begin
        for (int u = 0; u < 2; u++) begin
            m_left[u] = 0; m_done[u] = 0; m_z[u] = 0; m_res[u] = '0; m_pend[u] = '0;
        end
    end

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            nn = (u == 0) ? 8 : 2;
            if (reset) begin
                m_left[u] = 0; m_done[u] = 0; m_z[u] = 0; m_res[u] = '0;
            end else if (m_left[u] > 0) begin
                m_left[u]--;
                m_done[u] = (m_left[u] == 0);
                if (m_left[u] == 0) begin
                    m_res[u] = m_pend[u];
                    m_z[u]   = (m_pend[u][7:0] == 8'h00);
                end
            end else begin
                m_done[u] = 0;
                if (start) begin
                    m_left[u] = nn;
                    m_pend[u] = model_op(a, b, l, s, c_in);
                end
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("s1_busy", 32'(busy1), 32'(m_left[0] > 0));
            chk("s1_done", 32'(done1), 32'(m_done[0]));
            chk("s1_out",  32'(o1),    32'(m_res[0][7:0]));
            chk("s1_cout", 32'(c1),    32'(m_res[0][9]));
            chk("s1_ovf",  32'(v1),    32'(m_res[0][8]));
            chk("s1_zero", 32'(z1),    32'(m_z[0]));
            chk("s4_busy", 32'(busy4), 32'(m_left[1] > 0));
            chk("s4_done", 32'(done4), 32'(m_done[1]));
            chk("s4_out",  32'(o4),    32'(m_res[1][7:0]));
            chk("s4_cout", 32'(c4),    32'(m_res[1][9]));
            chk("s4_ovf",  32'(v4),    32'(m_res[1][8]));
            chk("s4_zero", 32'(z4),    32'(m_z[1]));
        end
    end

    // one op on an idle DUT; literal checks on the 1-bit-slice instance
    task automatic run_op(input string nm, input logic [7:0] aa, input logic [7:0] bv,
                          input logic ll, input logic [1:0] ss, input logic ci,
                          input logic [7:0] eo, input logic ec, input logic ev, input logic ez);
        int lat;
        a = aa; b = bv; l = ll; s = ss; c_in = ci; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            if (done1) lat = i;
        end
        chk({nm, "_lat"},  32'(lat), 32'd9);
        chk({nm, "_out"},  32'(o1),  32'(eo));
        chk({nm, "_cout"}, 32'(c1),  32'(ec));
        chk({nm, "_ovf"},  32'(v1),  32'(ev));
        chk({nm, "_zero"}, 32'(z1),  32'(ez));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int         cnt, d1, d2;
        logic [7:0] r1, r2, rmid;
        logic       cb2;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0; cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_out",  32'(o1),    32'h00);
        chk("rst_busy", 32'(busy1), 32'h0);
        chk("rst_done", 32'(done1), 32'h0);
        chk("rst_zero", 32'(z1),    32'h0);
        @(posedge clk); #1;

        run_op("add7f", 8'h7F, 8'h01, 1'b0, 2'b00, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("sub05", 8'h05, 8'h05, 1'b0, 2'b01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("addff", 8'hFF, 8'h01, 1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("xor",   8'hA5, 8'hFF, 1'b1, 2'b10, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
        run_op("not",   8'h0F, 8'h00, 1'b1, 2'b11, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
        run_op("and",   8'hF0, 8'h3C, 1'b1, 2'b00, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        run_op("inc7f", 8'h7F, 8'h00, 1'b0, 2'b10, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("dec00", 8'h00, 8'h00, 1'b0, 2'b11, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_op("subbr", 8'h03, 8'h05, 1'b0, 2'b01, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);

        // start pulsed again mid-RUN with different operands
        a = 8'h10; b = 8'h20; l = 1'b0; s = 2'b00; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 a = 8'hAA; b = 8'h55; s = 2'b01; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0; rmid = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done1) begin cnt++; rmid = o1; end
        end
        chk("midrun_dones", 32'(cnt),  32'd1);
        chk("midrun_out",   32'(rmid), 32'h30);
        @(posedge clk); #1;

        // reset during RUN cycle 4 aborts the op
        a = 8'h01; b = 8'h01; s = 2'b00; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy1), 32'h0);
        chk("abort_done", 32'(done1), 32'h0);
        chk("abort_out",  32'(o1),    32'h00);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done1 || done4) cnt++;
        end
        chk("abort_nodone", 32'(cnt), 32'd0);
        @(posedge clk); #1;

        // back-to-back on the 4-bit-slice instance with start held high
        a = 8'h12; b = 8'h34; l = 1'b0; s = 2'b00; c_in = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 a = 8'h10; b = 8'h20; s = 2'b01; c_in = 1'b0;
        d1 = 0; d2 = 0; r1 = '0; r2 = '0; cb2 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done4) begin
                if (d1 == 0) begin d1 = i; r1 = o4; end
                else if (d2 == 0) begin d2 = i; r2 = o4; cb2 = c4; end
            end
            if (i == 4) start = 1'b0;
        end
        chk("b2b_first_at", 32'(d1),      32'd3);
        chk("b2b_gap",      32'(d2 - d1), 32'd3);
        chk("b2b_out1",     32'(r1),      32'h47);
        chk("b2b_out2",     32'(r2),      32'hF0);
        chk("b2b_cout2",    32'(cb2),     32'h0);

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
